// File: rtl/sram_pkg.sv
// Shared types and constants for the two-port asynchronous SRAM arbiter.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // Active-low SRAM strobe levels
    localparam logic STB_ACTIVE = 1'b0;
    localparam logic STB_IDLE   = 1'b1;

    // Strobe wait counter covers WAIT_CYCLES in 0..7
    localparam int unsigned WAIT_W  = 3;
    localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant, registered last-served pointer.
module rr_arb2
    import sram_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               take_i,
    output logic [NUM_REQ-1:0] gnt_c_o
);

    // 1 means requester 1 was served last; reset value gives requester 0 priority
    logic last_q;

    // Pick the sole requester, or on a tie the one not served last
    always_comb begin
        gnt_c_o = '0;
        case (req_i)
            2'b01:   gnt_c_o = 2'b01;
            2'b10:   gnt_c_o = 2'b10;
            2'b11:   gnt_c_o = last_q ? 2'b01 : 2'b10;
            default: gnt_c_o = 2'b00;
        endcase
    end

    // Remember who was served when a grant is actually taken
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b1;
        end else if (take_i && (|gnt_c_o)) begin
            last_q <= gnt_c_o[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of an asynchronous SRAM; all SRAM pins and handshakes registered.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              CLK_IN,
    input  logic              RST_N_i,
    input  logic              REQ0_i,
    input  logic              WE0_i,
    input  logic [ADDR_W-1:0] ADDR0_i,
    input  logic [DATA_W-1:0] WDATA0_i,
    input  logic              REQ1_i,
    input  logic              WE1_i,
    input  logic [ADDR_W-1:0] ADDR1_i,
    input  logic [DATA_W-1:0] WDATA1_i,
    output logic              GNT0_o,
    output logic              GNT1_o,
    output logic              DONE0_o,
    output logic              DONE1_o,
    output logic [DATA_W-1:0] RDATA_o,
    output logic [ADDR_W-1:0] SRAM_ADDR_o,
    output logic [DATA_W-1:0] SRAM_DQ_o,
    output logic              SRAM_DQ_OE_o,
    input  logic [DATA_W-1:0] SRAM_DQ_i,
    output logic              SRAM_CS_N_o,
    output logic              SRAM_OE_N_o,
    output logic              SRAM_WE_N_o
);

    state_e              state_q;
    logic [WAIT_W-1:0]   cnt_q;
    logic                we_q;
    logic                served_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   dq_q;
    logic                dq_oe_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                cs_n_q;
    logic                oe_n_q;
    logic                we_n_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  done_q;

    logic [NUM_REQ-1:0]  req_c;
    logic [NUM_REQ-1:0]  arb_gnt_c;
    logic                take_c;
    logic                sel_we_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;

    assign req_c  = {REQ1_i, REQ0_i};
    assign take_c = (state_q == ST_IDLE) && (|req_c);

    rr_arb2 u_rr_arb2 (
        .clk_i   (CLK_IN),
        .rst_n_i (RST_N_i),
        .req_i   (req_c),
        .take_i  (take_c),
        .gnt_c_o (arb_gnt_c)
    );

    // Route the winning requester's payload toward the latch
    always_comb begin
        sel_we_c    = WE0_i;
        sel_addr_c  = ADDR0_i;
        sel_wdata_c = WDATA0_i;
        if (arb_gnt_c[1]) begin
            sel_we_c    = WE1_i;
            sel_addr_c  = ADDR1_i;
            sel_wdata_c = WDATA1_i;
        end
    end

    // Access sequencer; strobes are set one edge ahead so every pin is a flop output
    always_ff @(posedge CLK_IN or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            served_q <= 1'b0;
            addr_q   <= '0;
            dq_q     <= '0;
            dq_oe_q  <= 1'b0;
            rdata_q  <= '0;
            cs_n_q   <= STB_IDLE;
            oe_n_q   <= STB_IDLE;
            we_n_q   <= STB_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (take_c) begin
                        state_q  <= ST_SETUP;
                        gnt_q    <= arb_gnt_c;
                        served_q <= arb_gnt_c[1];
                        we_q     <= sel_we_c;
                        addr_q   <= sel_addr_c;
                        dq_q     <= sel_wdata_c;
                        cs_n_q   <= STB_ACTIVE;
                        oe_n_q   <= sel_we_c ? STB_IDLE : STB_ACTIVE;
                        dq_oe_q  <= sel_we_c;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_STROBE;
                    cnt_q   <= WAIT_W'(WAIT_CYCLES);
                    if (we_q) begin
                        we_n_q <= STB_ACTIVE;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RELEASE;
                        we_n_q  <= STB_IDLE;
                        oe_n_q  <= STB_IDLE;
                        if (!we_q) begin
                            rdata_q <= SRAM_DQ_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    cs_n_q  <= STB_IDLE;
                    dq_oe_q <= 1'b0;
                    done_q  <= served_q ? 2'b10 : 2'b01;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign GNT0_o       = gnt_q[0];
    assign GNT1_o       = gnt_q[1];
    assign DONE0_o      = done_q[0];
    assign DONE1_o      = done_q[1];
    assign RDATA_o      = rdata_q;
    assign SRAM_ADDR_o  = addr_q;
    assign SRAM_DQ_o    = dq_q;
    assign SRAM_DQ_OE_o = dq_oe_q;
    assign SRAM_CS_N_o  = cs_n_q;
    assign SRAM_OE_N_o  = oe_n_q;
    assign SRAM_WE_N_o  = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: WAIT_CYCLES=1 instance plus a WAIT_CYCLES=3 instance.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // WAIT_CYCLES=1 instance
    logic        req0, we0, req1, we1;
    logic [17:0] addr0, addr1;
    logic [15:0] wd0, wd1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] rdata, dq_o, dq_i;
    logic [17:0] sram_addr;
    logic        dq_oe, cs_n, oe_n, we_n;

    // WAIT_CYCLES=3 instance
    logic        q_req0, q_we0, q_req1, q_we1;
    logic [17:0] q_addr0, q_addr1;
    logic [15:0] q_wd0, q_wd1;
    logic        q_gnt0, q_gnt1, q_done0, q_done1;
    logic [15:0] q_rdata, q_dq_o, q_dq_i;
    logic [17:0] q_sram_addr;
    logic        q_dq_oe, q_cs_n, q_oe_n, q_we_n;

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) u_dut (
        .CLK_IN(clk), .RST_N_i(rst_n),
        .REQ0_i(req0), .WE0_i(we0), .ADDR0_i(addr0), .WDATA0_i(wd0),
        .REQ1_i(req1), .WE1_i(we1), .ADDR1_i(addr1), .WDATA1_i(wd1),
        .GNT0_o(gnt0), .GNT1_o(gnt1), .DONE0_o(done0), .DONE1_o(done1),
        .RDATA_o(rdata), .SRAM_ADDR_o(sram_addr), .SRAM_DQ_o(dq_o),
        .SRAM_DQ_OE_o(dq_oe), .SRAM_DQ_i(dq_i),
        .SRAM_CS_N_o(cs_n), .SRAM_OE_N_o(oe_n), .SRAM_WE_N_o(we_n)
    );

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(3)) u_dut3 (
        .CLK_IN(clk), .RST_N_i(rst_n),
        .REQ0_i(q_req0), .WE0_i(q_we0), .ADDR0_i(q_addr0), .WDATA0_i(q_wd0),
        .REQ1_i(q_req1), .WE1_i(q_we1), .ADDR1_i(q_addr1), .WDATA1_i(q_wd1),
        .GNT0_o(q_gnt0), .GNT1_o(q_gnt1), .DONE0_o(q_done0), .DONE1_o(q_done1),
        .RDATA_o(q_rdata), .SRAM_ADDR_o(q_sram_addr), .SRAM_DQ_o(q_dq_o),
        .SRAM_DQ_OE_o(q_dq_oe), .SRAM_DQ_i(q_dq_i),
        .SRAM_CS_N_o(q_cs_n), .SRAM_OE_N_o(q_oe_n), .SRAM_WE_N_o(q_we_n)
    );

    // Asynchronous SRAM models (low 8 address bits)
    logic [15:0] mem  [0:255];
    logic [15:0] mem3 [0:255];
    always @(posedge clk) if (!cs_n && !we_n) mem[sram_addr[7:0]] <= dq_o;
    always @(posedge clk) if (!q_cs_n && !q_we_n) mem3[q_sram_addr[7:0]] <= q_dq_o;
    assign dq_i   = (!cs_n && !oe_n) ? mem[sram_addr[7:0]] : 16'hBEEF;
    assign q_dq_i = (!q_cs_n && !q_oe_n) ? mem3[q_sram_addr[7:0]] : 16'hBEEF;

    // Bus invariants checked every cycle on both instances
    logic        p_we_n = 1'b1, p_q_we_n = 1'b1;
    logic [17:0] p_addr = '0, p_q_addr = '0;
    logic [15:0] p_dq = '0, p_q_dq = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (!we_n && !p_we_n && (sram_addr !== p_addr || dq_o !== p_dq)) begin
                fails++;
                $display("FAIL w1_hold: addr=%h dq=%h prev addr=%h dq=%h", sram_addr, dq_o, p_addr, p_dq);
            end
            tests++;
            if (dq_oe && !oe_n) begin
                fails++;
                $display("FAIL w1_contention: dq_oe=%b oe_n=%b required not both active", dq_oe, oe_n);
            end
            tests++;
            if (!q_we_n && !p_q_we_n && (q_sram_addr !== p_q_addr || q_dq_o !== p_q_dq)) begin
                fails++;
                $display("FAIL w3_hold: addr=%h dq=%h prev addr=%h dq=%h", q_sram_addr, q_dq_o, p_q_addr, p_q_dq);
            end
            tests++;
            if (q_dq_oe && !q_oe_n) begin
                fails++;
                $display("FAIL w3_contention: dq_oe=%b oe_n=%b required not both active", q_dq_oe, q_oe_n);
            end
        end
        p_we_n = we_n;     p_addr = sram_addr;     p_dq = dq_o;
        p_q_we_n = q_we_n; p_q_addr = q_sram_addr; p_q_dq = q_dq_o;
    end

    // Stimulus/measurement: p=0/1 selects requester on u_dut, p=2 requester 0 on u_dut3.
    // Times are in cycles counted from the drive edge (gnt_at) and from the grant (done_at).
    task automatic run_access(input int p, input logic w, input logic [17:0] a, input logic [15:0] d,
                              output int gnt_at, output int done_at, output int we_low,
                              output int oe_cnt, output int other);
        logic g, dn;
        gnt_at = -1; done_at = -1; we_low = 0; oe_cnt = 0; other = 0;
        @(negedge clk);
        case (p)
            0: begin req0 = 1'b1; we0 = w; addr0 = a; wd0 = d; end
            1: begin req1 = 1'b1; we1 = w; addr1 = a; wd1 = d; end
            default: begin q_req0 = 1'b1; q_we0 = w; q_addr0 = a; q_wd0 = d; end
        endcase
        for (int i = 1; i <= 10 && gnt_at < 0; i++) begin
            @(negedge clk);
            g = (p == 0) ? gnt0 : (p == 1) ? gnt1 : q_gnt0;
            if (g) gnt_at = i;
        end
        req0 = 1'b0; req1 = 1'b0; q_req0 = 1'b0;
        if (gnt_at >= 0) begin
            if ((p == 2) ? q_dq_oe : dq_oe) oe_cnt++;
            for (int i = 1; i <= 20 && done_at < 0; i++) begin
                @(negedge clk);
                if (!((p == 2) ? q_we_n : we_n)) we_low++;
                if ((p == 2) ? q_dq_oe : dq_oe) oe_cnt++;
                if (p == 0 && (gnt1 || done1)) other++;
                if (p == 1 && (gnt0 || done0)) other++;
                if (p == 2 && (q_gnt1 || q_done1)) other++;
                dn = (p == 0) ? done0 : (p == 1) ? done1 : q_done0;
                if (dn) done_at = i;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wd0 = '0; req1 = 0; we1 = 0; addr1 = '0; wd1 = '0;
        q_req0 = 0; q_we0 = 0; q_addr0 = '0; q_wd0 = '0; q_req1 = 0; q_we1 = 0; q_addr1 = '0; q_wd1 = '0;
        repeat (3) @(negedge clk);
        tests++; if ({cs_n, oe_n, we_n} !== 3'b111) begin fails++; $display("FAIL reset_strobes: got %b want 111", {cs_n, oe_n, we_n}); end
        tests++; if (dq_oe !== 1'b0) begin fails++; $display("FAIL reset_dq_oe: got %b want 0", dq_oe); end
        tests++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin fails++; $display("FAIL reset_handshake: got %b want 0000", {gnt0, gnt1, done0, done1}); end
        tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        tests++; if (sram_addr !== 18'h0) begin fails++; $display("FAIL reset_addr: got %h want 00000", sram_addr); end
        tests++; if ({q_cs_n, q_oe_n, q_we_n, q_dq_oe} !== 4'b1110) begin fails++; $display("FAIL reset_w3: got %b want 1110", {q_cs_n, q_oe_n, q_we_n, q_dq_oe}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if ({cs_n, gnt0, gnt1} !== 3'b100) begin fails++; $display("FAIL idle_after_reset: got %b want 100", {cs_n, gnt0, gnt1}); end
    endtask

    task automatic test_write();
        int ga, da, wl, oc, ot;
        run_access(0, 1'b1, 18'h00123, 16'h55AA, ga, da, wl, oc, ot);
        tests++; if (ga !== 1) begin fails++; $display("FAIL write0_gnt_latency: got %0d want 1", ga); end
        tests++; if (wl !== 2) begin fails++; $display("FAIL write0_we_low: got %0d want 2", wl); end
        tests++; if (da !== 4) begin fails++; $display("FAIL write0_done_latency: got %0d want 4", da); end
        tests++; if (ot !== 0) begin fails++; $display("FAIL write0_other_port: got %0d want 0", ot); end
        tests++; if (mem[8'h23] !== 16'h55AA) begin fails++; $display("FAIL write0_mem: got %h want 55aa", mem[8'h23]); end
        run_access(1, 1'b1, 18'h00040, 16'hA5C3, ga, da, wl, oc, ot);
        tests++; if (da !== 4) begin fails++; $display("FAIL write1_done_latency: got %0d want 4", da); end
        tests++; if (mem[8'h40] !== 16'hA5C3) begin fails++; $display("FAIL write1_mem: got %h want a5c3", mem[8'h40]); end
    endtask

    task automatic test_read();
        int ga, da, wl, oc, ot;
        run_access(0, 1'b0, 18'h00040, 16'h0000, ga, da, wl, oc, ot);
        tests++; if (rdata !== 16'hA5C3) begin fails++; $display("FAIL read0_rdata: got %h want a5c3", rdata); end
        run_access(0, 1'b1, 18'h0007F, 16'h0F0F, ga, da, wl, oc, ot);
        tests++; if (rdata !== 16'hA5C3) begin fails++; $display("FAIL rdata_held_over_write: got %h want a5c3", rdata); end
        run_access(1, 1'b0, 18'h00123, 16'h0000, ga, da, wl, oc, ot);
        tests++; if (da !== 4) begin fails++; $display("FAIL read1_done_latency: got %0d want 4", da); end
        tests++; if (rdata !== 16'h55AA) begin fails++; $display("FAIL read1_rdata: got %h want 55aa", rdata); end
        tests++; if (oc !== 0) begin fails++; $display("FAIL read1_dq_oe: high %0d cycles want 0", oc); end
        tests++; if (wl !== 0) begin fails++; $display("FAIL read1_we_low: got %0d want 0", wl); end
    endtask

    task automatic test_contention();
        int n = 0, both = 0;
        int who [4];
        int at [4];
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 18'h00040;
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00123;
        for (int i = 1; i <= 40 && n < 4; i++) begin
            @(negedge clk);
            if (gnt0 && gnt1) both++;
            if (gnt0 || gnt1) begin who[n] = gnt1 ? 1 : 0; at[n] = i; n++; end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);
        tests++; if (n !== 4) begin fails++; $display("FAIL contention_grants: got %0d want 4", n); end
        tests++; if (both !== 0) begin fails++; $display("FAIL contention_double: got %0d want 0", both); end
        if (n == 4) begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (who[k] !== (k % 2)) begin fails++; $display("FAIL contention_order[%0d]: got %0d want %0d", k, who[k], k % 2); end
            end
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (at[k+1] - at[k] !== 5) begin fails++; $display("FAIL contention_spacing[%0d]: got %0d want 5", k, at[k+1] - at[k]); end
            end
        end
    endtask

    task automatic test_sole();
        int g0 = 0, g1 = 0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00010; wd0 = 16'h1111;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (gnt0) g0++;
            if (gnt1) g1++;
        end
        req0 = 1'b0;
        tests++; if (g0 !== 3) begin fails++; $display("FAIL sole_gnt0: got %0d want 3", g0); end
        tests++; if (g1 !== 0) begin fails++; $display("FAIL sole_gnt1: got %0d want 0", g1); end
        tests++; if (mem[8'h10] !== 16'h1111) begin fails++; $display("FAIL sole_mem: got %h want 1111", mem[8'h10]); end
    endtask

    task automatic test_reset_mid();
        int seen = 0, dn = 0, got = -1;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00020; wd0 = 16'h2222;
        for (int i = 0; i < 10 && seen == 0; i++) begin @(negedge clk); if (gnt0) seen = 1; end
        req0 = 1'b0;
        tests++; if (seen !== 1) begin fails++; $display("FAIL rmid_gnt: timeout waiting for gnt0"); end
        @(negedge clk);
        tests++; if (we_n !== 1'b0) begin fails++; $display("FAIL rmid_in_strobe: we_n=%b want 0", we_n); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({cs_n, oe_n, we_n, dq_oe} !== 4'b1110) begin fails++; $display("FAIL rmid_strobes: got %b want 1110", {cs_n, oe_n, we_n, dq_oe}); end
        tests++; if (sram_addr !== 18'h0) begin fails++; $display("FAIL rmid_addr: got %h want 00000", sram_addr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (done0 || done1) dn++; end
        tests++; if (dn !== 0) begin fails++; $display("FAIL rmid_no_done: got %0d want 0", dn); end
        req0 = 1'b1; we0 = 1'b0; addr0 = 18'h00010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00123;
        for (int i = 0; i < 10 && got < 0; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) got = gnt1 ? 1 : 0;
        end
        req0 = 1'b0; req1 = 1'b0;
        tests++; if (got !== 0) begin fails++; $display("FAIL rmid_tie_after_reset: got %0d want 0", got); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_wait3();
        int ga, da, wl, oc, ot;
        run_access(2, 1'b1, 18'h00123, 16'h3C3C, ga, da, wl, oc, ot);
        tests++; if (ga !== 1) begin fails++; $display("FAIL w3_gnt_latency: got %0d want 1", ga); end
        tests++; if (wl !== 4) begin fails++; $display("FAIL w3_we_low: got %0d want 4", wl); end
        tests++; if (da !== 6) begin fails++; $display("FAIL w3_write_done: got %0d want 6", da); end
        tests++; if (mem3[8'h23] !== 16'h3C3C) begin fails++; $display("FAIL w3_mem: got %h want 3c3c", mem3[8'h23]); end
        run_access(2, 1'b0, 18'h00123, 16'h0000, ga, da, wl, oc, ot);
        tests++; if (da !== 6) begin fails++; $display("FAIL w3_read_done: got %0d want 6", da); end
        tests++; if (q_rdata !== 16'h3C3C) begin fails++; $display("FAIL w3_rdata: got %h want 3c3c", q_rdata); end
        tests++; if (oc !== 0) begin fails++; $display("FAIL w3_read_dq_oe: high %0d cycles want 0", oc); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_sole();
        test_reset_mid();
        test_wait3();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, extra strobe cycles (0..7) beyond the one-cycle minimum.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named CLK_IN and RST_N_i.
REQ-005 CLK_IN  input  1  system clock (12 MHz).
REQ-006 RST_N_i  input  1  asynchronous active-low reset.
REQ-007 REQn_i (n=0,1)  input  1  requester n access request; held high until GNTn_o.
REQ-008 WEn_i  input  1  requester n write (1) or read (0).
REQ-009 ADDRn_i  input  ADDR_W  requester n word address.
REQ-010 WDATAn_i  input  DATA_W  requester n write data.
REQ-011 GNTn_o  output  1  one-cycle pulse: request n accepted, inputs latched.
REQ-012 DONEn_o  output  1  one-cycle pulse: requester n access complete.
REQ-013 RDATA_o  output  DATA_W  read data, valid on any DONEn_o after a read, held until next read completes.
REQ-014 SRAM_ADDR_o  output  ADDR_W  SRAM address.
REQ-015 SRAM_DQ_o / SRAM_DQ_OE_o / SRAM_DQ_i  output DATA_W / output 1 / input DATA_W  bidirectional data split; tristate buffer lives in top.
REQ-016 SRAM_CS_N_o, SRAM_OE_N_o, SRAM_WE_N_o  output  1 each  active-low SRAM strobes.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, STROBE, RELEASE.
REQ-018 IDLE: if any REQn_i high, select winner, pulse GNTn_o, latch WE/ADDR/WDATA, go SETUP; else stay.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, winner is the requester not served last; a sole requester always wins; after reset, requester 0 has priority.
REQ-020 SETUP (1 cycle): CS_N=0, address driven; read: OE_N=0; write: DQ_OE=1, DQ_o=latched data, WE_N=1.
REQ-021 STROBE (WAIT_CYCLES+1 cycles, down-counter): write: WE_N=0; read: OE_N=0; read data SHALL be registered from SRAM_DQ_i on the last STROBE cycle.
REQ-022 RELEASE (1 cycle): WE_N=1, OE_N=1, address and DQ_o/DQ_OE still held (hold time), DONEn_o pulses for the served requester, then IDLE.
REQ-023 Latency GNT-to-DONE SHALL be WAIT_CYCLES+3 cycles; back-to-back accesses have a mandatory 1-cycle IDLE gap, total period WAIT_CYCLES+4 cycles.
REQ-024 Requests arriving during a non-IDLE state SHALL wait; no GNT outside IDLE.
REQ-025 Address, WE_N and DQ_o SHALL never change while WE_N=0; DQ_OE and OE_N SHALL never both be active.
REQ-026 Outside an access, CS_N=1, OE_N=1, WE_N=1, DQ_OE=0.

Reset
REQ-027 RST_N_i low SHALL immediately force state IDLE, all strobes high, DQ_OE=0, GNT/DONE=0, RDATA_o=0, SRAM_ADDR_o=0, round-robin pointer to requester 0, including mid-access (aborted access reports no DONE).

Structure
REQ-028 State encoding and strobe-level constants SHALL live in shared package sram_pkg.
REQ-029 Round-robin selection SHALL be sub-module rr_arb2 (two requests, last-served register, grant vector out); all else in sram_arbiter.

Verification
REQ-030 Write: REQ0, WE0=1, ADDR0=0x00123, WDATA0=0x55AA -> GNT0 next edge, WE_N low exactly 2 cycles (WAIT_CYCLES=1), DONE0 4 cycles after GNT0, SRAM model holds 0x55AA.
REQ-031 Read back: REQ1 read 0x00123 -> DONE1 after 4 cycles, RDATA_o=0x55AA, DQ_OE never high.
REQ-032 Contention: REQ0 and REQ1 held high continuously -> grants alternate 0,1,0,1; each grant 5 cycles apart.
REQ-033 Sole requester: REQ0 held for 3 accesses -> three GNT0 pulses, no GNT1.
REQ-034 Reset during STROBE of a write -> all strobes high and DQ_OE=0 in same cycle, no DONE, next REQ1 vs REQ0 tie grants 0.
REQ-035 WAIT_CYCLES=3 -> strobe 4 cycles, DONE 6 cycles after GNT; assertions of REQ-025 hold throughout.
